// File: rtl/tiny16_mem_arbiter.sv
// Two-master arbiter for the tiny16 memory port: registered grant FSM with
// round-robin or fixed priority, plus a watchdog that retires unacknowledged cycles.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | sample m0/m1 valid, latch the winner onto s_*
// ST_BUSY    | s_valid high, wait for s_ready or watchdog expiry
// ST_RELEASE | ready/error pulse visible, valids ignored for one cycle
module tiny16_mem_arbiter #(
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT        = 64,
  parameter int unsigned TO_BITS        = 7
) (
  input  logic        clk,
  input  logic        nreset,

  input  logic        m0_valid,
  input  logic        m0_nwr,
  input  logic [15:0] m0_address,
  input  logic [15:0] m0_wdata,
  output logic        m0_ready,
  output logic [15:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_nwr,
  input  logic [15:0] m1_address,
  input  logic [15:0] m1_wdata,
  output logic        m1_ready,
  output logic [15:0] m1_rdata,

  output logic        s_valid,
  output logic        s_nwr,
  output logic [15:0] s_address,
  output logic [15:0] s_wdata,
  input  logic        s_ready,
  input  logic [15:0] s_rdata,

  output logic        grant,
  output logic        bus_error
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam bit                 TO_EN     = (TIMEOUT != 0);
  localparam int unsigned        TO_LAST_I = TO_EN ? TIMEOUT - 1 : 0;
  localparam logic [TO_BITS-1:0] TO_LAST   = TO_BITS'(TO_LAST_I);

  logic [1:0]         state;
  logic               last_grant;
  logic [TO_BITS-1:0] to_cnt;

  logic               pick_m1;
  logic               timeout_hit;
  logic               retire;
  logic [15:0]        retire_rdata;

  // On a tie, round-robin hands the bus to whoever did not own it last.
  always_comb begin
    pick_m1 = m1_valid;
    if (m0_valid && m1_valid) begin
      pick_m1 = FIXED_PRIORITY ? 1'b0 : ~last_grant;
    end
  end

  assign timeout_hit = TO_EN && (to_cnt == TO_LAST);
  assign retire      = s_ready || timeout_hit;

  // s_ready has precedence, so a watchdog expiry on the same edge is a normal completion.
  always_comb begin
    retire_rdata = 16'hFFFF;
    if (s_ready) begin
      retire_rdata = s_nwr ? s_rdata : 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      to_cnt     <= '0;
      grant      <= 1'b0;
      s_valid    <= 1'b0;
      s_nwr      <= 1'b0;
      s_address  <= 16'h0000;
      s_wdata    <= 16'h0000;
      m0_ready   <= 1'b0;
      m0_rdata   <= 16'h0000;
      m1_ready   <= 1'b0;
      m1_rdata   <= 16'h0000;
      bus_error  <= 1'b0;
    end else begin
      m0_ready  <= 1'b0;
      m0_rdata  <= 16'h0000;
      m1_ready  <= 1'b0;
      m1_rdata  <= 16'h0000;
      bus_error <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (m0_valid || m1_valid) begin
            grant      <= pick_m1;
            last_grant <= pick_m1;
            s_valid    <= 1'b1;
            s_nwr      <= pick_m1 ? m1_nwr     : m0_nwr;
            s_address  <= pick_m1 ? m1_address : m0_address;
            s_wdata    <= pick_m1 ? m1_wdata   : m0_wdata;
            to_cnt     <= '0;
            state      <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (retire) begin
            s_valid   <= 1'b0;
            bus_error <= ~s_ready;
            if (grant) begin
              m1_ready <= 1'b1;
              m1_rdata <= retire_rdata;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= retire_rdata;
            end
            state <= ST_RELEASE;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny16_mem_arbiter.sv
// Bench for tiny16_mem_arbiter: round-robin and fixed-priority instances share
// stimulus and are each compared every cycle against a transaction-level model.
module tb_tiny16_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        nreset;
  logic        m0_valid, m0_nwr, m1_valid, m1_nwr, s_ready;
  logic [15:0] m0_address, m0_wdata, m1_address, m1_wdata, s_rdata;

  logic [1:0]  o_s_valid, o_s_nwr, o_grant, o_m0_ready, o_m1_ready, o_berr;
  logic [15:0] o_s_address [2];
  logic [15:0] o_s_wdata   [2];
  logic [15:0] o_m0_rdata  [2];
  logic [15:0] o_m1_rdata  [2];

  // expected outputs and model bookkeeping, index 0 = round-robin, 1 = fixed priority
  bit   [1:0]  e_s_valid, e_s_nwr, e_grant, e_m0_ready, e_m1_ready, e_berr;
  logic [15:0] e_s_address [2];
  logic [15:0] e_s_wdata   [2];
  logic [15:0] e_m0_rdata  [2];
  logic [15:0] e_m1_rdata  [2];
  int          owner [2];
  int          waited [2];
  bit          cooldown [2];
  bit          last_owner [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tiny16_mem_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT(TMO), .TO_BITS(3)) dut_rr (
    .clk(clk), .nreset(nreset),
    .m0_valid(m0_valid), .m0_nwr(m0_nwr), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_ready(o_m0_ready[0]), .m0_rdata(o_m0_rdata[0]),
    .m1_valid(m1_valid), .m1_nwr(m1_nwr), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_ready(o_m1_ready[0]), .m1_rdata(o_m1_rdata[0]),
    .s_valid(o_s_valid[0]), .s_nwr(o_s_nwr[0]), .s_address(o_s_address[0]),
    .s_wdata(o_s_wdata[0]), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(o_grant[0]), .bus_error(o_berr[0])
  );

  tiny16_mem_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT(TMO), .TO_BITS(3)) dut_fp (
    .clk(clk), .nreset(nreset),
    .m0_valid(m0_valid), .m0_nwr(m0_nwr), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_ready(o_m0_ready[1]), .m0_rdata(o_m0_rdata[1]),
    .m1_valid(m1_valid), .m1_nwr(m1_nwr), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_ready(o_m1_ready[1]), .m1_rdata(o_m1_rdata[1]),
    .s_valid(o_s_valid[1]), .s_nwr(o_s_nwr[1]), .s_address(o_s_address[1]),
    .s_wdata(o_s_wdata[1]), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(o_grant[1]), .bus_error(o_berr[1])
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1; waited[i] = 0; cooldown[i] = 1'b0; last_owner[i] = 1'b1;
      e_s_valid[i] = 1'b0; e_s_nwr[i] = 1'b0; e_grant[i] = 1'b0;
      e_m0_ready[i] = 1'b0; e_m1_ready[i] = 1'b0; e_berr[i] = 1'b0;
      e_s_address[i] = '0; e_s_wdata[i] = '0; e_m0_rdata[i] = '0; e_m1_rdata[i] = '0;
    end
  endtask

  // One rising edge of the shared bus: a transaction is owned, waits for the slave
  // for at most TMO edges, then leaves a one-cycle gap before the next grant.
  task automatic model_edge(input int i);
    int          w;
    bit          done;
    logic [15:0] rd;
    done = 1'b0;
    rd   = '0;
    e_m0_ready[i] = 1'b0; e_m1_ready[i] = 1'b0; e_berr[i] = 1'b0;
    e_m0_rdata[i] = '0;   e_m1_rdata[i] = '0;
    if (cooldown[i]) begin
      cooldown[i] = 1'b0;
    end else if (owner[i] < 0) begin
      if (m0_valid || m1_valid) begin
        if (m0_valid && m1_valid) w = (i == 1) ? 0 : (last_owner[i] ? 0 : 1);
        else w = m1_valid ? 1 : 0;
        owner[i] = w; waited[i] = 0; last_owner[i] = (w == 1);
        e_grant[i] = (w == 1); e_s_valid[i] = 1'b1;
        e_s_nwr[i]     = (w == 1) ? m1_nwr     : m0_nwr;
        e_s_address[i] = (w == 1) ? m1_address : m0_address;
        e_s_wdata[i]   = (w == 1) ? m1_wdata   : m0_wdata;
      end
    end else if (s_ready) begin
      done = 1'b1;
      rd   = e_s_nwr[i] ? s_rdata : 16'h0000;
    end else if (waited[i] + 1 >= TMO) begin
      done = 1'b1;
      rd   = 16'hFFFF;
      e_berr[i] = 1'b1;
    end else begin
      waited[i]++;
    end
    if (done) begin
      if (owner[i] == 1) begin e_m1_ready[i] = 1'b1; e_m1_rdata[i] = rd; end
      else begin e_m0_ready[i] = 1'b1; e_m0_rdata[i] = rd; end
      e_s_valid[i] = 1'b0; owner[i] = -1; cooldown[i] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.s_valid[%0d]", tag, i),   16'(o_s_valid[i]),  16'(e_s_valid[i]));
      chk($sformatf("%s.s_nwr[%0d]", tag, i),     16'(o_s_nwr[i]),    16'(e_s_nwr[i]));
      chk($sformatf("%s.s_address[%0d]", tag, i), o_s_address[i],     e_s_address[i]);
      chk($sformatf("%s.s_wdata[%0d]", tag, i),   o_s_wdata[i],       e_s_wdata[i]);
      chk($sformatf("%s.grant[%0d]", tag, i),     16'(o_grant[i]),    16'(e_grant[i]));
      chk($sformatf("%s.m0_ready[%0d]", tag, i),  16'(o_m0_ready[i]), 16'(e_m0_ready[i]));
      chk($sformatf("%s.m0_rdata[%0d]", tag, i),  o_m0_rdata[i],      e_m0_rdata[i]);
      chk($sformatf("%s.m1_ready[%0d]", tag, i),  16'(o_m1_ready[i]), 16'(e_m1_ready[i]));
      chk($sformatf("%s.m1_rdata[%0d]", tag, i),  o_m1_rdata[i],      e_m1_rdata[i]);
      chk($sformatf("%s.bus_error[%0d]", tag, i), 16'(o_berr[i]),     16'(e_berr[i]));
      chk($sformatf("%s.both_ready[%0d]", tag, i),
          16'(o_m0_ready[i] & o_m1_ready[i]), 16'h0000);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    #2 nreset = 1'b0;
    #1 model_reset();
    check_all("reset");
    #1 nreset = 1'b1;
  endtask

  int sv_cnt;
  int seen;
  int gq0 [$];
  int gq1 [$];

  initial begin
    nreset = 1'b0;
    m0_valid = 1'b0; m0_nwr = 1'b0; m0_address = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_nwr = 1'b0; m1_address = '0; m1_wdata = '0;
    s_ready = 1'b0; s_rdata = '0;
    model_reset();
    #3 check_all("por");
    @(posedge clk);
    #1 nreset = 1'b1;

    // M0 read, slave answers on the third BUSY edge
    m0_valid = 1'b1; m0_nwr = 1'b1; m0_address = 16'h0123;
    sv_cnt = 0;
    step("t1");
    sv_cnt += int'(o_s_valid[0]);
    step("t1");
    sv_cnt += int'(o_s_valid[0]);
    step("t1");
    sv_cnt += int'(o_s_valid[0]);
    s_ready = 1'b1; s_rdata = 16'hBEEF;
    step("t1");
    sv_cnt += int'(o_s_valid[0]);
    chk("t1_m0_ready", 16'(o_m0_ready[0]), 16'h0001);
    chk("t1_m0_rdata", o_m0_rdata[0], 16'hBEEF);
    chk("t1_grant", 16'(o_grant[0]), 16'h0000);
    s_ready = 1'b0; m0_valid = 1'b0;
    step("t1");
    chk("t1_s_valid_cycles", 16'(sv_cnt), 16'd3);

    // both masters held from reset, slave always ready
    apply_reset();
    m0_valid = 1'b1; m0_nwr = 1'b1; m0_address = 16'h1000;
    m1_valid = 1'b1; m1_nwr = 1'b1; m1_address = 16'h2000;
    s_ready = 1'b1; s_rdata = 16'h00A5;
    for (int c = 0; c < 12; c++) begin
      step("t2");
      if (o_m0_ready[0] || o_m1_ready[0]) gq0.push_back(int'(o_grant[0]));
      if (o_m0_ready[1] || o_m1_ready[1]) gq1.push_back(int'(o_grant[1]));
    end
    chk("t2_rr_count", 16'(gq0.size()), 16'd4);
    chk("t3_fp_count", 16'(gq1.size()), 16'd4);
    for (int k = 0; k < gq0.size(); k++) chk($sformatf("t2_rr_grant%0d", k), 16'(gq0[k]), 16'(k % 2));
    for (int k = 0; k < gq1.size(); k++) chk($sformatf("t3_fp_grant%0d", k), 16'(gq1[k]), 16'h0000);
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    step("idle");
    step("idle");

    // M1 write, slave never answers: watchdog retires it
    m1_valid = 1'b1; m1_nwr = 1'b0; m1_address = 16'h8000; m1_wdata = 16'h3C3C;
    sv_cnt = 0; seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      step("t4");
      if (o_m1_ready[0]) begin
        seen = 1;
        chk("t4_bus_error", 16'(o_berr[0]), 16'h0001);
        chk("t4_m1_rdata", o_m1_rdata[0], 16'hFFFF);
      end else begin
        sv_cnt += int'(o_s_valid[0]);
      end
    end
    chk("t4_ready_seen", 16'(seen), 16'h0001);
    chk("t4_s_valid_cycles", 16'(sv_cnt), 16'd4);
    m1_valid = 1'b0;
    step("t4");

    // s_ready on the very edge the watchdog would fire
    m0_valid = 1'b1; m0_nwr = 1'b1; m0_address = 16'h4444;
    step("t5");
    repeat (TMO - 1) step("t5");
    s_ready = 1'b1; s_rdata = 16'h5A5A;
    step("t5");
    chk("t5_m0_ready", 16'(o_m0_ready[0]), 16'h0001);
    chk("t5_bus_error", 16'(o_berr[0]), 16'h0000);
    chk("t5_m0_rdata", o_m0_rdata[0], 16'h5A5A);
    s_ready = 1'b0; m0_valid = 1'b0;
    step("t5");

    // reset while M0 owns the bus; last owner M0 would lose a tie without it
    m0_valid = 1'b1; m0_nwr = 1'b0; m0_address = 16'h0777; m0_wdata = 16'h1234;
    step("t6");
    step("t6");
    apply_reset();
    chk("t6_s_valid", 16'(o_s_valid[0]), 16'h0000);
    m1_valid = 1'b1; m1_nwr = 1'b1; m1_address = 16'h0888;
    s_ready = 1'b1;
    step("t6");
    chk("t6_tie_grant", 16'(o_grant[0]), 16'h0000);
    step("t6");
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    step("t6");

    // randomized traffic; masters follow the round-robin instance's handshake
    for (int c = 0; c < 600; c++) begin
      step("rnd");
      if (!m0_valid || e_m0_ready[0]) begin
        m0_valid = ($urandom_range(0, 2) == 0);
        m0_nwr = 1'($urandom_range(0, 1));
        m0_address = 16'($urandom()); m0_wdata = 16'($urandom());
      end
      if (!m1_valid || e_m1_ready[0]) begin
        m1_valid = ($urandom_range(0, 2) == 0);
        m1_nwr = 1'($urandom_range(0, 1));
        m1_address = 16'($urandom()); m1_wdata = 16'($urandom());
      end
      s_ready = ($urandom_range(0, 3) == 0);
      s_rdata = 16'($urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
